// File: rtl/wb_regbank_pkg.sv
// wb_regbank_pkg: shared types and constants for the Wishbone register bank.
//   - wb_state_e    : bus handshake FSM states
//   - REG_*         : register indices in the bank
//   - CTRL_*        : bit positions inside CTRL
//   - MISS_RDATA    : data returned for reads outside the decoded window
//   - lane_merge()  : byte-lane write merge helper
package wb_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_DOORBELL = 2;

  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int CTRL_LED_LSB    = 4;
  localparam int CTRL_LED_MSB    = 7;

  localparam logic [31:0] MISS_RDATA = 32'h0000_0000;

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) res[8*n +: 8] = new_w[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_regbank_irq.sv
// wb_regbank_irq: doorbell pending flag with write-1-to-clear and enable gate.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   status_we_i       : committed write to STATUS this cycle
//   doorbell_we_i     : committed write to DOORBELL this cycle
//   bit0_one_i        : written data has lane 0 selected and bit0 = 1
//   irq_en_i          : CTRL irq enable
//   pending_o         : pending flag (STATUS bit0)
//   irq_o             : level interrupt = pending & irq_en
module wb_regbank_irq
  import wb_regbank_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic status_we_i,
  input  logic doorbell_we_i,
  input  logic bit0_one_i,
  input  logic irq_en_i,
  output logic pending_o,
  output logic irq_o
);

  logic pending_q, pending_d;

  // Only one access commits per cycle, so set and clear never coincide.
  always_comb begin
    pending_d = pending_q;
    if (doorbell_we_i && bit0_one_i)    pending_d = 1'b1;
    else if (status_we_i && bit0_one_i) pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= 1'b0;
    else          pending_q <= pending_d;
  end

  assign pending_o = pending_q;
  assign irq_o     = pending_q & irq_en_i;

endmodule

// File: rtl/wb_regbank_slave.sv
// wb_regbank_slave: Wishbone classic slave with a bank of 32-bit registers,
// byte-lane writes, programmable wait states, doorbell interrupt and LEDs.
// Optional feature macro: WB_REGBANK_IRQ_EN (STATUS/DOORBELL/irq_en logic).
// Parameters: NREGS (pow2, 4..64), WAIT_STATES (0..15), BASE_ADDR.
// Ports:
//   clk, reset_n                : Wishbone clock, async active-low reset
//   wb_address, wb_dat_i        : byte address ([1:0] ignored), write data
//   wb_sel_i                    : byte-lane enables for writes
//   wb_cyc_i, wb_stb_i, wb_wr_i : cycle, strobe, write-enable
//   wb_dat_o, wb_ack_o          : read data, single-cycle acknowledge
//   wb_irq_o                    : level interrupt
//   led_out                     : CTRL[7:4]
module wb_regbank_slave
  import wb_regbank_pkg::*;
#(
  parameter int unsigned NREGS       = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_address,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_wr_i,
  output logic        wb_ack_o,
  output logic        wb_irq_o,
  output logic [3:0]  led_out
);

  localparam int ADDR_LSB = $clog2(NREGS * 4);
  localparam int IDX_W    = $clog2(NREGS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(REG_CTRL);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(REG_STATUS);
  localparam logic [IDX_W-1:0] IDX_DOORBELL = IDX_W'(REG_DOORBELL);

  // Address decode
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             req;
  assign hit = (wb_address[31:ADDR_LSB] == BASE_ADDR[31:ADDR_LSB]);
  assign idx = wb_address[ADDR_LSB-1:2];
  assign req = wb_cyc_i & wb_stb_i;

  // Bus FSM with registered ack and read data
  wb_state_e   state_q;
  logic [3:0]  cnt_q;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_word;
  logic        wr_commit;

  // Write commits on the edge leaving ACK, only if the master still holds
  // the request; address/data are taken from the ACK cycle.
  assign wr_commit = (state_q == ACK) & req & wb_wr_i & hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (WAIT_STATES == 0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              rdata_q <= rd_word;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            rdata_q <= rd_word;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Register storage; STATUS/DOORBELL slots are never stored here.
  logic [NREGS-1:0][31:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_commit && idx != IDX_STATUS && idx != IDX_DOORBELL)
      regs_d[idx] = lane_merge(regs_q[idx], wb_dat_i, wb_sel_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

`ifdef WB_REGBANK_IRQ_EN
  logic pending;

  wb_regbank_irq u_irq (
    .clk           (clk),
    .reset_n       (reset_n),
    .status_we_i   (wr_commit && idx == IDX_STATUS),
    .doorbell_we_i (wr_commit && idx == IDX_DOORBELL),
    .bit0_one_i    (wb_sel_i[0] & wb_dat_i[0]),
    .irq_en_i      (regs_q[REG_CTRL][CTRL_IRQ_EN_BIT]),
    .pending_o     (pending),
    .irq_o         (wb_irq_o)
  );
`else
  assign wb_irq_o = 1'b0;
`endif

  // Read mux; sel is ignored on reads.
  always_comb begin
    rd_word = MISS_RDATA;
    if (hit) begin
      if (idx == IDX_STATUS) begin
`ifdef WB_REGBANK_IRQ_EN
        rd_word = {31'b0, pending};
`else
        rd_word = 32'h0;
`endif
      end else if (idx == IDX_DOORBELL) begin
        rd_word = 32'h0;
      end else begin
        rd_word = regs_q[idx];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdata_q;
  assign led_out  = regs_q[IDX_CTRL][CTRL_LED_MSB:CTRL_LED_LSB];

  // Bits intentionally not consumed: byte offset and the never-stored slots.
  logic unused_sink;
  assign unused_sink = &{1'b0, wb_address[1:0], regs_q[REG_STATUS], regs_q[REG_DOORBELL]};

endmodule

// File: tb/tb_wb_regbank_slave.sv
module tb_wb_regbank_slave;

  localparam int          NREGS = 16;
  localparam int          WS    = 1;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] wb_address, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i, led_out;
  logic        wb_cyc_i, wb_stb_i, wb_wr_i, wb_ack_o, wb_irq_o;

  wb_regbank_slave #(.NREGS(NREGS), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .wb_address(wb_address), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_wr_i(wb_wr_i), .wb_ack_o(wb_ack_o), .wb_irq_o(wb_irq_o), .led_out(led_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain array of words plus the pending flag.
  logic [31:0] mem [NREGS];
  bit          pend;

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + NREGS * 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int i;
    if (!in_window(a)) return 32'h0;
    i = int'((a - BASE) / 4);
`ifdef WB_REGBANK_IRQ_EN
    if (i == 1) return {31'b0, pend};
    if (i == 2) return 32'h0;
`else
    if (i == 1 || i == 2) return 32'h0;
`endif
    return mem[i];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int i;
    if (!in_window(a)) return;
    i = int'((a - BASE) / 4);
    if (i == 1) begin
`ifdef WB_REGBANK_IRQ_EN
      if (s[0] && d[0]) pend = 1'b0;
`endif
    end else if (i == 2) begin
`ifdef WB_REGBANK_IRQ_EN
      if (s[0] && d[0]) pend = 1'b1;
`endif
    end else begin
      for (int n = 0; n < 4; n++)
        if (s[n]) mem[i][8*n +: 8] = d[8*n +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mem[i] = 32'h0;
    pend = 1'b0;
  endtask

  function automatic logic [31:0] exp_irq();
`ifdef WB_REGBANK_IRQ_EN
    return {31'b0, pend & mem[0][0]};
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_led();
    return {28'b0, mem[0][7:4]};
  endfunction

  // Scoreboard
  typedef struct {
    bit          rd;
    logic [31:0] d;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset_n && wb_ack_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.rd) chk(mon_e.name, wb_dat_o, mon_e.d);
      end
    end
  end

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_wr_i = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input bit we, input logic [31:0] d,
                        input logic [3:0] s, input string nm);
    exp_t e;
    int   n;
    bit   got;
    e.rd = !we; e.d = model_read(a); e.name = nm;
    sb.push_back(e);
    if (we) model_write(a, d, s);
    wb_address = a; wb_dat_i = d; wb_sel_i = s; wb_wr_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (wb_ack_o) got = 1'b1;
    end
    if (!got) begin
      chk({nm, "_ack_timeout"}, 32'(got), 32'd1);
      idle_bus();
      void'(sb.pop_back());
      return;
    end
    chk({nm, "_latency"}, 32'(n), 32'(1 + WS));
    @(posedge clk); #1;
    idle_bus();
    chk({nm, "_ack_pulse"}, 32'(wb_ack_o), 32'd0);
    chk({nm, "_led"}, 32'(led_out), exp_led());
    chk({nm, "_irq"}, 32'(wb_irq_o), exp_irq());
  endtask

  function automatic logic [31:0] ra(input int i);
    return BASE + 32'(i * 4);
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw;
    logic [31:0] a, d;
    reset_n = 1'b0;
    wb_address = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
    idle_bus();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_irq", 32'(wb_irq_o), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write and readback
    access(ra(3), 1'b1, 32'hA5A5_0000, 4'hF, "wr_idx3");
    access(ra(3), 1'b0, 32'h0, 4'h0, "rd_idx3");
    chk("idx3_const", mem[3], 32'hA5A5_0000);

    // Partial lanes
    access(ra(4), 1'b1, 32'h1122_3344, 4'b0101, "wr_idx4_lanes");
    access(ra(4), 1'b0, 32'h0, 4'hF, "rd_idx4_lanes");
    chk("idx4_const", mem[4], 32'h0022_0044);
    access(ra(4), 1'b1, 32'hFFFF_FFFF, 4'h0, "wr_idx4_sel0");
    access(ra(4), 1'b0, 32'h0, 4'h0, "rd_idx4_sel0");

    // CTRL / doorbell / status
    access(ra(0), 1'b1, 32'h0000_00A1, 4'hF, "wr_ctrl");
    chk("led_A", 32'(led_out), 32'hA);
    access(ra(2), 1'b1, 32'h0000_0001, 4'hF, "wr_doorbell");
    access(ra(1), 1'b0, 32'h0, 4'hF, "rd_status");
    access(ra(2), 1'b0, 32'h0, 4'hF, "rd_doorbell");
    access(ra(1), 1'b1, 32'h0000_0001, 4'hF, "wr_status_w1c");
    chk("irq_cleared", 32'(wb_irq_o), 32'd0);

    // Abort during WAIT: no ack, no write
    wb_address = ra(5); wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
    wb_wr_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0;
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw |= wb_ack_o;
    end
    idle_bus();
    chk("abort_no_ack", 32'(saw), 32'd0);
    access(ra(5), 1'b0, 32'h0, 4'hF, "rd_idx5_after_abort");

    // Miss
    access(BASE + NREGS * 4, 1'b0, 32'h0, 4'hF, "rd_miss");
    access(BASE + NREGS * 4, 1'b1, 32'hFFFF_FFFF, 4'hF, "wr_miss");
    access(BASE - 4, 1'b1, 32'h5555_5555, 4'hF, "wr_miss_low");
    for (int i = 0; i < NREGS; i++) access(ra(i), 1'b0, 32'h0, 4'h0, "rd_after_miss");

    // Reset while in WAIT
    access(ra(0), 1'b1, 32'h0000_00F0, 4'hF, "wr_ctrl_pre_rst");
    wb_address = ra(6); wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF;
    wb_wr_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_mid_led", 32'(led_out), 32'd0);
    model_reset();
    sb.delete();
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    access(ra(6), 1'b0, 32'h0, 4'hF, "rd_idx6_post_rst");
    access(ra(6), 1'b1, 32'hCAFE_F00D, 4'hF, "wr_idx6_post_rst");
    access(ra(6), 1'b0, 32'h0, 4'hF, "rd_idx6_post_rst2");

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) a = BASE + NREGS * 4 + 32'(4 * $urandom_range(0, 15));
      else                            a = ra(int'($urandom_range(0, NREGS - 1)));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
      access(a, 1'($urandom_range(0, 1)), d, 4'($urandom_range(0, 15)), "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regbank_slave.md
# wb_regbank_slave

Wishbone classic slave that answers the Wishbone master port of the PCI target bridge. It provides a bank of 32-bit control/scratch registers, byte-lane writes, programmable wait states, a doorbell interrupt back to the bridge, and LED drive. It sits on the bridge's wb_* bus and runs on the bridge's Wishbone clock.

## Interface
- NREGS, 16: number of 32-bit registers; power of two, 4..64.
- WAIT_STATES, 1: extra cycles inserted before ack; 0..15.
- BASE_ADDR, 32'h0000_0000: byte base address; aligned to NREGS*4.
- clk  in  1  Wishbone clock, driven from the bridge's wb_clk_o.
- reset_n  in  1  reset; asynchronous, active-low.
- wb_address  in  32  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data from master.
- wb_dat_o  out  32  read data to master.
- wb_sel_i  in  4  byte-lane enables; bit n = bits [8n+7:8n].
- wb_cyc_i, wb_stb_i, wb_wr_i  in  1 each  cycle, strobe, write-enable.
- wb_ack_o  out  1  transfer acknowledge.
- wb_irq_o  out  1  level interrupt to the bridge.
- led_out  out  4  LED drive.

## Operation
- Hit: wb_address[31:log2(NREGS*4)] == BASE_ADDR of the same bits. Index = wb_address[log2(NREGS*4)-1:2].
- Register map:
  - 0 CTRL: bit0 irq_en, bits[7:4] led, others RW scratch.
  - 1 STATUS: bit0 pending; write-1-to-clear.
  - 2 DOORBELL: write with bit0=1 sets pending; reads 0.
  - 3..NREGS-1: RW scratch.
- Writes update only the lanes with wb_sel_i set; wb_sel_i=0 is acked with no change. Reads return the full word and ignore wb_sel_i.
- Miss: still acked. Reads return 32'h0; writes are dropped. There is no error port.
- FSM has three states:
  - IDLE: on cyc&stb, go to WAIT with cnt=WAIT_STATES-1; if WAIT_STATES==0, go to ACK.
  - WAIT: decrement cnt; go to ACK when cnt==0; go to IDLE if cyc or stb drops (abort).
  - ACK: wb_ack_o=1. Go to IDLE unconditionally on the next edge.
- Read data is latched on the edge entering ACK and held while ack is high.
- A write commits on the edge leaving ACK, only if cyc&stb&wr are still high in the ACK cycle. Address and data are sampled in the ACK cycle.
- An abort never commits a write.
- wb_irq_o = pending & irq_en. led_out = CTRL[7:4].
- In the same cycle, a DOORBELL set and a STATUS clear cannot collide, because there is one access per cycle.

## Timing
- Reset values: all registers 0, wb_dat_o=0, wb_ack_o=0, wb_irq_o=0, led_out=0, state IDLE.
- Latency: if stb is first seen high in cycle k, ack is high in cycle k+1+WAIT_STATES.
- ack is a single-cycle pulse per access.
- At least one IDLE cycle separates accesses, so back-to-back throughput is one transfer per 2+WAIT_STATES cycles.
- reset_n asserted mid-access: ack is cleared immediately (asynchronous) and no write commits.
- CTRL/STATUS effects appear on led_out and wb_irq_o one cycle after the write commits.

## Configuration
- WB_REGBANK_IRQ_EN defined: STATUS, DOORBELL and irq_en logic are present, as described above.
- WB_REGBANK_IRQ_EN undefined:
  - wb_irq_o is tied to 0.
  - Indices 1 and 2 read 0 and ignore writes.
  - CTRL bit0 becomes plain scratch.

## Structure
- Package wb_regbank_pkg holds:
  - state enum (IDLE, WAIT, ACK);
  - register index constants (REG_CTRL=0, REG_STATUS=1, REG_DOORBELL=2);
  - CTRL bit positions;
  - miss read value.
- Sub-module wb_regbank_irq holds the pending/enable/W1C logic; it is instantiated only under WB_REGBANK_IRQ_EN.

## Test plan
- WAIT_STATES=1: write 32'hA5A5_0000 to index 3 with sel=4'hF, stb high from cycle 0 -> ack in cycle 2 only; a read of index 3 returns 32'hA5A5_0000.
- Write 32'h1122_3344 to index 4 with sel=4'b0101, starting from 0 -> readback 32'h0022_0044.
- Write CTRL=32'h0000_00A1, then DOORBELL=1 -> led_out=4'hA and wb_irq_o=1. Write STATUS=1 -> wb_irq_o=0.
- Drop cyc during WAIT on a write to index 5 (WAIT_STATES=3) -> no ack, index 5 unchanged.
- Read address BASE_ADDR+NREGS*4 -> acked with data 32'h0; a write there changes no register.
- Assert reset_n low while the FSM is in WAIT -> ack=0 and led_out=0 immediately; after release, the next access completes normally.
